// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sorter result receiver.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RES,
        CHECK,
        DRAIN
    } rx_state_t;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // Width that holds the sum of cnt elements of dw bits without overflow.
    function automatic int unsigned sum_w(input int unsigned dw, input int unsigned cnt);
        return dw + $clog2(cnt);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == CNT_SAT) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/cmp_order_chk.sv
// Combinational order/sum/xor evaluation of one element vector.
module cmp_order_chk
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_CNT   = 32,
    parameter string       COM_STYLE  = "UP"
) (
    input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]       vec_i,
    output logic                                      order_bad_o,
    output logic [sum_w(DATA_WIDTH, DATA_CNT)-1:0]    vec_sum_o,
    output logic [DATA_WIDTH-1:0]                     vec_xor_o
);

    localparam int unsigned SumW = sum_w(DATA_WIDTH, DATA_CNT);
    localparam bit          Up   = (COM_STYLE == "UP");

    always_comb begin
        order_bad_o = 1'b0;
        vec_sum_o   = '0;
        vec_xor_o   = '0;
        for (int i = 0; i < int'(DATA_CNT); i++) begin
            vec_sum_o = vec_sum_o + SumW'(vec_i[i]);
            vec_xor_o = vec_xor_o ^ vec_i[i];
        end
        // Equal neighbours are legal in either direction.
        for (int i = 0; i < int'(DATA_CNT) - 1; i++) begin
            if (Up ? (vec_i[i+1] < vec_i[i]) : (vec_i[i+1] > vec_i[i])) begin
                order_bad_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_result_rx.sv
// Snoops a sorter write, captures its result, checks order and content, then drains it.
module cmp_result_rx
    import cmp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_CNT   = 32,
    parameter string       COM_STYLE  = "UP",
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 write_en_i,
    input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  write_data_i,
    input  logic                                 compare_en_i,
    input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  compare_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [DATA_WIDTH-1:0]                out_data_o,
    output logic [$clog2(DATA_CNT)-1:0]          out_idx_o,
    output logic                                 out_last_o,
    output logic                                 busy_o,
    output logic                                 err_order_o,
    output logic                                 err_sum_o,
    output logic                                 err_proto_o,
    output logic                                 err_timeout_o,
    output logic [15:0]                          pass_cnt_o,
    output logic [15:0]                          fail_cnt_o
);

    localparam int unsigned SumW = sum_w(DATA_WIDTH, DATA_CNT);
    localparam int unsigned IdxW = $clog2(DATA_CNT);
    localparam int unsigned TmrW = $clog2(TIMEOUT);

    rx_state_t                            state_q, state_d;
    logic [TmrW-1:0]                      timer_q, timer_d;
    logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  cap_q, cap_d;
    logic [SumW-1:0]                      ref_sum_q, ref_sum_d;
    logic [DATA_WIDTH-1:0]                ref_xor_q, ref_xor_d;
    logic [IdxW-1:0]                      idx_q, idx_d;
    logic [15:0]                          pass_q, pass_d, fail_q, fail_d;

    logic                  ref_order_unused;
    logic [SumW-1:0]       wr_sum, res_sum;
    logic [DATA_WIDTH-1:0] wr_xor, res_xor;
    logic                  res_order_bad;

    cmp_order_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_CNT   (DATA_CNT),
        .COM_STYLE  (COM_STYLE)
    ) u_ref_chk (
        .vec_i       (write_data_i),
        .order_bad_o (ref_order_unused),
        .vec_sum_o   (wr_sum),
        .vec_xor_o   (wr_xor)
    );

    cmp_order_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_CNT   (DATA_CNT),
        .COM_STYLE  (COM_STYLE)
    ) u_res_chk (
        .vec_i       (cap_q),
        .order_bad_o (res_order_bad),
        .vec_sum_o   (res_sum),
        .vec_xor_o   (res_xor)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cap_d         = cap_q;
        ref_sum_d     = ref_sum_q;
        ref_xor_d     = ref_xor_q;
        idx_d         = idx_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        err_order_o   = 1'b0;
        err_sum_o     = 1'b0;
        err_timeout_o = 1'b0;
        // Offending strobes are flagged here and otherwise ignored by the FSM below.
        err_proto_o   = (write_en_i && (state_q != IDLE)) ||
                        (compare_en_i && (state_q != WAIT_RES));

        unique case (state_q)
            IDLE: begin
                if (write_en_i) begin
                    state_d   = WAIT_RES;
                    ref_sum_d = wr_sum;
                    ref_xor_d = wr_xor;
                    timer_d   = '0;
                end
            end
            WAIT_RES: begin
                if (compare_en_i) begin
                    cap_d   = compare_data_i;
                    state_d = CHECK;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    err_timeout_o = 1'b1;
                    fail_d        = sat_inc(fail_q);
                    state_d       = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CHECK: begin
                err_order_o = res_order_bad;
                err_sum_o   = (res_sum != ref_sum_q) || (res_xor != ref_xor_q);
                if (err_order_o || err_sum_o) begin
                    fail_d = sat_inc(fail_q);
                end else begin
                    pass_d = sat_inc(pass_q);
                end
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready_i) begin
                    if (idx_q == IdxW'(DATA_CNT - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid_o = (state_q == DRAIN);
    assign out_data_o  = out_valid_o ? cap_q[idx_q] : '0;
    assign out_idx_o   = idx_q;
    assign out_last_o  = out_valid_o && (idx_q == IdxW'(DATA_CNT - 1));
    assign busy_o      = (state_q != IDLE);
    assign pass_cnt_o  = pass_q;
    assign fail_cnt_o  = fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            cap_q     <= '0;
            ref_sum_q <= '0;
            ref_xor_q <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cap_q     <= cap_d;
            ref_sum_q <= ref_sum_d;
            ref_xor_q <= ref_xor_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

endmodule

// File: tb/tb_cmp_result_rx.sv
// Scoreboard bench for cmp_result_rx: directed vectors, drain beats checked by a monitor.
module tb_cmp_result_rx;

    typedef logic [31:0][7:0] vec_t;
    typedef struct {
        logic [7:0] d;
        logic [4:0] idx;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_en = 1'b0;
    vec_t        write_data = '0;
    logic        compare_en = 1'b0;
    vec_t        compare_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        err_order, err_sum, err_proto, err_timeout;
    logic [15:0] pass_cnt, fail_cnt;

    int n_vec = 0;
    int n_mis = 0;
    int n_order = 0, n_sum = 0, n_proto = 0, n_timeout = 0;
    beat_t sb[$];

    logic       stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic [4:0] prev_idx;

    always #5 clk = ~clk;

    cmp_result_rx #(
        .DATA_WIDTH (8),
        .DATA_CNT   (32),
        .COM_STYLE  ("UP"),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_en_i     (write_en),
        .write_data_i   (write_data),
        .compare_en_i   (compare_en),
        .compare_data_i (compare_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_idx_o      (out_idx),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .err_order_o    (err_order),
        .err_sum_o      (err_sum),
        .err_proto_o    (err_proto),
        .err_timeout_o  (err_timeout),
        .pass_cnt_o     (pass_cnt),
        .fail_cnt_o     (fail_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t ramp(input int base, input int step);
        vec_t v;
        for (int i = 0; i < 32; i++) v[i] = 8'(base + step * i);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write, then the result 5 cycles later; returns in the CHECK cycle.
    task automatic send(input vec_t wr, input vec_t res);
        write_en   = 1'b1;
        write_data = wr;
        tick();
        write_en = 1'b0;
        repeat (4) tick();
        compare_en   = 1'b1;
        compare_data = res;
        for (int i = 0; i < 32; i++) sb.push_back('{res[i], 5'(i), (i == 31)});
        tick();
        compare_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_within_budget", 32'(busy), 0);
    endtask

    // Monitor: pops expected beats on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_order)   n_order++;
            if (err_sum)     n_sum++;
            if (err_proto)   n_proto++;
            if (err_timeout) n_timeout++;
            if (stall_prev) begin
                check("stall_data_hold", 32'(out_data), 32'(prev_data));
                check("stall_idx_hold", 32'(out_idx), 32'(prev_idx));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.d));
                    check("beat_idx", 32'(out_idx), 32'(b.idx));
                    check("beat_last", 32'(out_last), 32'(b.last));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        vec_t v;
        int   k;

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pass", 32'(pass_cnt), 0);
        check("rst_fail", 32'(fail_cnt), 0);
        rst_n = 1'b1;
        tick();

        // 1: reversed write, ascending result
        send(ramp(31, -1), ramp(0, 1));
        check("t1_order", 32'(err_order), 0);
        check("t1_sum", 32'(err_sum), 0);
        check("t1_check_no_valid", 32'(out_valid), 0);
        tick();
        check("t1_first_valid", 32'(out_valid), 1);
        check("t1_first_data", 32'(out_data), 0);
        wait_idle(100);
        check("t1_pass", 32'(pass_cnt), 1);
        check("t1_fail", 32'(fail_cnt), 0);

        // 2: elements 3,4 swapped
        v = ramp(0, 1);
        v[3] = 8'd4;
        v[4] = 8'd3;
        send(ramp(31, -1), v);
        check("t2_order", 32'(err_order), 1);
        check("t2_sum", 32'(err_sum), 0);
        wait_idle(100);
        check("t2_fail", 32'(fail_cnt), 1);
        check("t2_pass", 32'(pass_cnt), 1);

        // 3: element 7 bumped by one, order still non-decreasing
        v = ramp(0, 1);
        v[7] = 8'd8;
        send(ramp(31, -1), v);
        check("t3_order", 32'(err_order), 0);
        check("t3_sum", 32'(err_sum), 1);
        wait_idle(100);
        check("t3_fail", 32'(fail_cnt), 2);

        // 4: timeout after 16 waiting cycles
        write_en   = 1'b1;
        write_data = ramp(5, 3);
        tick();
        write_en = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check("t4_timeout_cycle", 32'(err_timeout), 32'(c == 16));
            tick();
        end
        check("t4_busy_after", 32'(busy), 0);
        check("t4_fail", 32'(fail_cnt), 3);

        // 5: stalled drain, stray write in DRAIN, stray compare in IDLE
        send(ramp(62, -2), ramp(0, 2));
        check("t5_order", 32'(err_order), 0);
        check("t5_sum", 32'(err_sum), 0);
        tick();
        k = 0;
        while (busy && k < 200) begin
            out_ready = (k % 2 == 0);
            if (k == 3) begin
                write_en   = 1'b1;
                write_data = ramp(1, 1);
                #1;
                check("t5_proto_wr", 32'(err_proto), 1);
            end else begin
                write_en = 1'b0;
            end
            tick();
            k++;
        end
        write_en  = 1'b0;
        out_ready = 1'b1;
        check("t5_drained", 32'(busy), 0);
        tick();
        check("t5_write_ignored", 32'(busy), 0);
        compare_en = 1'b1;
        #1;
        check("t5_proto_cmp", 32'(err_proto), 1);
        tick();
        compare_en = 1'b0;
        check("t5_cmp_ignored", 32'(busy), 0);
        check("t5_pass", 32'(pass_cnt), 2);
        check("t5_fail", 32'(fail_cnt), 3);

        // 6: asynchronous reset at drain beat 10
        send(ramp(31, -1), ramp(0, 1));
        k = 0;
        while (!(out_valid && out_idx == 5'd10) && k < 100) begin
            tick();
            k++;
        end
        check("t6_reached_beat10", 32'(out_idx), 10);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_idx", 32'(out_idx), 0);
        check("t6_data", 32'(out_data), 0);
        check("t6_last", 32'(out_last), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_pass", 32'(pass_cnt), 0);
        check("t6_fail", 32'(fail_cnt), 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(ramp(31, -1), ramp(0, 1));
        check("t6b_order", 32'(err_order), 0);
        check("t6b_sum", 32'(err_sum), 0);
        wait_idle(100);
        check("t6b_pass", 32'(pass_cnt), 1);
        check("t6b_fail", 32'(fail_cnt), 0);

        // Whole-run pulse totals and scoreboard drain
        tick();
        check("sb_empty", 32'(sb.size()), 0);
        check("total_order", 32'(n_order), 1);
        check("total_sum", 32'(n_sum), 1);
        check("total_proto", 32'(n_proto), 2);
        check("total_timeout", 32'(n_timeout), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
